// File: rtl/tx_medida_ascii.sv
// Serial 7E2 transmitter for a 3-digit BCD measurement followed by a terminator character.
// Optional macro TX_MEDIDA_CRLF_EN appends CR and LF after the terminator.
module tx_medida_ascii #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [6:0]  TERMINADOR   = 7'h23
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inicio,
  input  logic [11:0] dados,
  output logic        saida_serial,
  output logic        pronto,
  output logic        ocupado,
  output logic [3:0]  db_estado
);

  localparam int unsigned TickW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(CLKS_PER_BIT - 1);
  // PROXIMO occupies the final cycle of the last stop bit, so TRANSMITE leaves one tick early.
  localparam logic [TickW-1:0] TickStop = TickW'(CLKS_PER_BIT - 2);
  localparam logic [3:0]       BitLast  = 4'd10;
`ifdef TX_MEDIDA_CRLF_EN
  localparam logic [2:0] LastChar = 3'd5;
`else
  localparam logic [2:0] LastChar = 3'd3;
`endif

  typedef enum logic [3:0] {
    StInicial   = 4'h0,
    StPrepara   = 4'h1,
    StTransmite = 4'h2,
    StProximo   = 4'h3,
    StFinal     = 4'hF
  } state_e;

  state_e           state_q, state_d;
  logic [11:0]      dados_q;
  logic [2:0]       char_q, char_d;
  logic [3:0]       bit_q, bit_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [10:0]      shift_q, shift_d;
  logic [6:0]       char_code;
  logic [10:0]      frame;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StInicial;
      dados_q <= '0;
      char_q  <= '0;
      bit_q   <= '0;
      tick_q  <= '0;
      shift_q <= '1;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      bit_q   <= bit_d;
      tick_q  <= tick_d;
      shift_q <= shift_d;
      if (state_q == StInicial && inicio) begin
        dados_q <= dados;
      end
    end
  end

  // Character selection and 7E2 framing: {stop, stop, parity, data[6:0], start}.
  always_comb begin
    char_code = TERMINADOR;
    case (char_q)
      3'd0:    char_code = {3'b011, dados_q[11:8]};
      3'd1:    char_code = {3'b011, dados_q[7:4]};
      3'd2:    char_code = {3'b011, dados_q[3:0]};
`ifdef TX_MEDIDA_CRLF_EN
      3'd4:    char_code = 7'h0D;
      3'd5:    char_code = 7'h0A;
`endif
      default: char_code = TERMINADOR;
    endcase
    frame = {2'b11, ^char_code, char_code, 1'b0};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StInicial:   if (inicio) state_d = StPrepara;
      StPrepara:   state_d = StTransmite;
      StTransmite: if (bit_q == BitLast && tick_q == TickStop) state_d = StProximo;
      StProximo:   state_d = (char_q == LastChar) ? StFinal : StPrepara;
      StFinal:     state_d = StInicial;
      default:     state_d = StInicial;
    endcase
  end

  // PREPARA is the first cycle of the start bit, so timing resumes at tick 1 in TRANSMITE.
  always_comb begin
    char_d  = char_q;
    bit_d   = bit_q;
    tick_d  = tick_q;
    shift_d = shift_q;
    case (state_q)
      StInicial: begin
        char_d = '0;
        bit_d  = '0;
        tick_d = '0;
      end
      StPrepara: begin
        shift_d = frame;
        bit_d   = '0;
        tick_d  = TickW'(1);
      end
      StTransmite: begin
        if (tick_q == TickLast) begin
          tick_d  = '0;
          bit_d   = bit_q + 4'd1;
          shift_d = {1'b1, shift_q[10:1]};
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StProximo: begin
        char_d = char_q + 3'd1;
        tick_d = '0;
      end
      StFinal: begin
        char_d = '0;
        bit_d  = '0;
        tick_d = '0;
      end
      default: begin
        char_d  = '0;
        bit_d   = '0;
        tick_d  = '0;
        shift_d = '1;
      end
    endcase
  end

  always_comb begin
    saida_serial = 1'b1;
    pronto       = 1'b0;
    ocupado      = 1'b1;
    db_estado    = state_q;
    case (state_q)
      StInicial:   ocupado = 1'b0;
      StPrepara:   saida_serial = 1'b0;
      StTransmite: saida_serial = shift_q[0];
      StProximo:   saida_serial = 1'b1;
      StFinal:     pronto = 1'b1;
      default:     ocupado = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_tx_medida_ascii.sv
// Bench for tx_medida_ascii: line-sampling receiver feeds a frame queue checked against expected frames.
module tb_tx_medida_ascii;

  localparam int unsigned CPB = 4;
`ifdef TX_MEDIDA_CRLF_EN
  localparam int NCHAR = 6;
`else
  localparam int NCHAR = 4;
`endif
  localparam int MSG_CYC = 11 * NCHAR * CPB + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        inicio = 1'b0;
  logic [11:0] dados = '0;
  logic        saida_serial;
  logic        pronto;
  logic        ocupado;
  logic [3:0]  db_estado;

  int vectors = 0;
  int miscompares = 0;

  logic [10:0] exp_q[$];
  logic [10:0] rx_q[$];

  tx_medida_ascii #(
    .CLKS_PER_BIT(CPB),
    .TERMINADOR  (7'h23)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .inicio      (inicio),
    .dados       (dados),
    .saida_serial(saida_serial),
    .pronto      (pronto),
    .ocupado     (ocupado),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  // Receiver: detect start, sample mid-bit, hand complete 11-bit frames to rx_q.
  logic        rx_busy = 1'b0;
  int unsigned rx_cnt = 0;
  logic [10:0] rx_bits = '0;

  always @(negedge clock) begin
    if (!reset) begin
      rx_busy <= 1'b0;
    end else if (!rx_busy) begin
      if (!saida_serial) begin
        rx_busy <= 1'b1;
        rx_cnt  <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt % CPB == CPB / 2) begin
        rx_bits[rx_cnt / CPB] <= saida_serial;
        if (rx_cnt / CPB == 10) begin
          rx_q.push_back({saida_serial, rx_bits[9:0]});
          rx_busy <= 1'b0;
        end
      end
    end
  end

  function automatic logic [10:0] frame_of(input logic [6:0] c);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      f[i+1] = c[i];
      ones += int'(c[i]);
    end
    f[8]  = (ones % 2) == 1;
    f[9]  = 1'b1;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    assert (got === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic push_msg(input logic [11:0] d);
    exp_q.push_back(frame_of({3'b011, d[11:8]}));
    exp_q.push_back(frame_of({3'b011, d[7:4]}));
    exp_q.push_back(frame_of({3'b011, d[3:0]}));
    exp_q.push_back(frame_of(7'h23));
`ifdef TX_MEDIDA_CRLF_EN
    exp_q.push_back(frame_of(7'h0D));
    exp_q.push_back(frame_of(7'h0A));
`endif
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      if (rx_q.size() == 0) begin
        check({tag, "_missing"}, 0, exp_q.size());
        exp_q.delete();
      end else begin
        check(tag, rx_q.pop_front(), exp_q.pop_front());
      end
    end
    check({tag, "_extra"}, rx_q.size(), 0);
  endtask

  // Called at a negedge; drives inicio now and counts cycles until pronto (+tail).
  task automatic run_msg(input string tag, input logic [11:0] d, input int pulse_at,
                         input int rst_at, input int tail, output int n_pronto,
                         output int n_pulses, output bit busy_all);
    n_pronto = -1;
    n_pulses = 0;
    busy_all = 1'b1;
    inicio   = 1'b1;
    dados    = d;
    for (int n = 1; n <= MSG_CYC + tail + 20; n++) begin
      @(negedge clock);
      inicio = (n == pulse_at);
      if (n == pulse_at) dados = ~d;
      if (n == 1) begin
        check({tag, "_start_bit"}, saida_serial, 0);
        check({tag, "_prepara"}, db_estado, 4'h1);
      end
      if (pronto) begin
        n_pulses++;
        if (n_pronto < 0) n_pronto = n;
      end
      if (!ocupado && (n_pronto < 0 || n == n_pronto)) busy_all = 1'b0;
      if (n == rst_at) begin
        reset = 1'b0;
        #1;
        check({tag, "_rst_line"}, saida_serial, 1);
        check({tag, "_rst_busy"}, ocupado, 0);
        check({tag, "_rst_pronto"}, pronto, 0);
        check({tag, "_rst_state"}, db_estado, 4'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        return;
      end
      if (n_pronto >= 0 && n >= n_pronto + tail) return;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int np, npl;
    bit busy;

    #1;
    check("reset_line", saida_serial, 1);
    check("reset_pronto", pronto, 0);
    check("reset_busy", ocupado, 0);
    check("reset_state", db_estado, 4'h0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // 0x31 0x32 0x33 '#', plus exact first frame and pronto latency
    push_msg(12'h123);
    run_msg("m123", 12'h123, -1, -1, 0, np, npl, busy);
    check("m123_pronto_lat", np, MSG_CYC);
    check("m123_busy", busy, 1);
    if (rx_q.size() > 0) check("m123_frame0", rx_q[0], 11'b111_0110_0010);
    drain("m123");

    // parity bits 0,0,0,1
    @(negedge clock);
    push_msg(12'h090);
    run_msg("m090", 12'h090, -1, -1, 0, np, npl, busy);
    check("m090_pronto_lat", np, MSG_CYC);
    if (rx_q.size() >= 4) begin
      check("m090_par0", rx_q[0][8], 0);
      check("m090_par1", rx_q[1][8], 0);
      check("m090_par2", rx_q[2][8], 0);
      check("m090_par3", rx_q[3][8], 1);
    end
    drain("m090");

    // inicio mid-message with new dados is ignored
    @(negedge clock);
    push_msg(12'h478);
    run_msg("glitch", 12'h478, 50, -1, MSG_CYC + 20, np, npl, busy);
    check("glitch_pronto_lat", np, MSG_CYC);
    check("glitch_pronto_cnt", npl, 1);
    drain("glitch");

    // reset mid-message: only the first frame completed
    @(negedge clock);
    exp_q.push_back(frame_of(7'h32));
    run_msg("abort", 12'h246, -1, 60, 0, np, npl, busy);
    drain("abort");
    @(negedge clock);
    push_msg(12'h987);
    run_msg("after_rst", 12'h987, -1, -1, 0, np, npl, busy);
    check("after_rst_pronto_lat", np, MSG_CYC);
    drain("after_rst");

    // back-to-back with non-decimal nibbles
    @(negedge clock);
    push_msg(12'hABF);
    run_msg("b2b_a", 12'hABF, -1, -1, 0, np, npl, busy);
    check("b2b_a_pronto_lat", np, MSG_CYC);
    @(negedge clock);
    check("b2b_idle_state", db_estado, 4'h0);
    check("b2b_idle_line", saida_serial, 1);
    push_msg(12'h105);
    run_msg("b2b_b", 12'h105, -1, -1, 0, np, npl, busy);
    check("b2b_b_pronto_lat", np, MSG_CYC);
    drain("b2b");

    @(negedge clock);
    push_msg(12'h456);
    run_msg("m456", 12'h456, -1, -1, 0, np, npl, busy);
    check("m456_pronto_lat", np, MSG_CYC);
    check("m456_busy", busy, 1);
    drain("m456");

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tx_medida_ascii.md
TX_MEDIDA_ASCII -- requirements
Module: tx_medida_ascii

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per serial bit (50 MHz / 115200 baud).
REQ-002 SHALL have parameter TERMINADOR, default 7'h23, meaning the 7-bit ASCII character sent after the digits ('#').
REQ-003 SHALL have port clock  input  1  meaning the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port inicio  input  1  meaning a one-cycle start pulse, driven by the sensor interface's measurement-ready strobe.
REQ-006 SHALL have port dados  input  12  meaning a 3-digit BCD measurement: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-007 SHALL have port saida_serial  output  1  meaning the asynchronous serial line (idle high).
REQ-008 SHALL have port pronto  output  1  meaning a one-cycle pulse when the whole message has been sent.
REQ-009 SHALL have port ocupado  output  1  meaning high while a message is in progress.
REQ-010 SHALL have port db_estado  output  4  meaning the FSM state code, for 7-segment debug.

Function
REQ-011 SHALL use frame format 7E2: start bit 0, 7 data bits LSB first, even parity, then two stop bits of 1 (11 bits per character).
REQ-012 SHALL, when inicio=1 in INICIAL, latch dados and move to PREPARA on that same edge; later changes to dados SHALL NOT affect the message.
REQ-013 SHALL send characters in this order: {3'b011,dados[11:8]}, {3'b011,dados[7:4]}, {3'b011,dados[3:0]}, TERMINADOR.
REQ-014 SHALL NOT check nibbles above 9; they are sent as {3'b011,nibble} (0x3A-0x3F).
REQ-015 SHALL drive the first start bit starting on the cycle after inicio is sampled (latency of 1 cycle).
REQ-016 SHALL hold each bit for exactly CLKS_PER_BIT cycles, with no idle gap between characters.
REQ-017 SHALL use these FSM states and db_estado codes: INICIAL 0, PREPARA 1, TRANSMITE 2, PROXIMO 3, FINAL F; any other code SHALL go to INICIAL.
REQ-018 SHALL take these transitions:
- INICIAL to PREPARA on inicio.
- PREPARA loads the shift register of the current character, then goes to TRANSMITE.
- TRANSMITE goes to PROXIMO after the 11th bit period.
- PROXIMO goes to PREPARA (zero-duration bookkeeping) if characters remain, else to FINAL.
- FINAL goes to INICIAL after one cycle.
REQ-019 SHALL budget the PREPARA/PROXIMO cycles inside the bit timing, so that message length is exactly 11*N*CLKS_PER_BIT cycles from the first start edge.
REQ-020 SHALL assert pronto only in FINAL (1 cycle), right after the last stop bit ends.
REQ-021 SHALL drive ocupado=1 in every state except INICIAL.
REQ-022 SHALL ignore inicio when not in INICIAL; it is neither queued nor allowed to restart the message.
REQ-023 SHALL start a new message if inicio is asserted in the cycle after FINAL (INICIAL), with no extra gap.
REQ-024 SHALL drive saida_serial=1 in INICIAL and FINAL.

Reset
REQ-025 SHALL, while reset=0, immediately force: state INICIAL, saida_serial=1, pronto=0, ocupado=0, db_estado=0, all counters cleared.
REQ-026 SHALL abort a message if reset is asserted mid-frame; there is no resume, and the partial frame is truncated.
REQ-027 SHALL treat the first inicio after reset release as a fresh message.

Configuration
REQ-028 SHALL support macro TX_MEDIDA_CRLF_EN:
- defined: after TERMINADOR, send 7'h0D then 7'h0A, for N=6 characters.
- undefined: N=4, and the CR/LF logic is absent.

Verification (CLKS_PER_BIT=4 in sim)
REQ-029 SHALL cover: dados=12'h123, inicio pulse -> line carries 0x31,0x32,0x33,0x23; the first frame is 0,1,0,0,0,1,1,0,1,1,1; pronto is high exactly 177 cycles after inicio (176 without the start cycle); ocupado is high throughout.
REQ-030 SHALL cover: dados=12'h090 -> 0x30,0x39,0x30,0x23, with parity bits 0,0,0,1 respectively.
REQ-031 SHALL cover: second inicio 50 cycles into the message, and dados changed -> message unchanged, single pronto.
REQ-032 SHALL cover: reset=0 at cycle 60 of the message -> saida_serial=1 and ocupado=0 with no clock edge; a new inicio after release sends the full message correctly.
REQ-033 SHALL cover: inicio in the cycle after pronto -> next start bit follows on the next cycle, no idle bit.
REQ-034 SHALL cover: with TX_MEDIDA_CRLF_EN, dados=12'h456 -> 0x34,0x35,0x36,0x23,0x0D,0x0A, and pronto after 264 bit-cycles (+1).
